// File: rtl/hsem_pkg.sv
// Shared definitions for the HSEM task dispatcher: default sizes, FSM encoding
// and the round-robin pointer advance helper.
package hsem_pkg;

  localparam int HSEM_TASK_W  = 32;
  localparam int HSEM_ID_W    = 5;
  localparam int HSEM_TMO_CYC = 1024;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_OFFER = 3'd2,
    ST_RUN   = 3'd3,
    ST_CMPL  = 3'd4
  } hsem_state_e;

  // Slot after the one just retired, wrapping at the vector width.
  function automatic int rr_next(input int id, input int width);
    if (id + 1 >= width) begin
      return 0;
    end else begin
      return id + 1;
    end
  endfunction

endpackage

// File: rtl/hsem_rr_arb.sv
// Combinational round-robin picker: lowest set pending bit at or above
// i_rr_ptr, wrapping from TASK_W-1 back to 0.
module hsem_rr_arb
  import hsem_pkg::*;
#(
  parameter int TASK_W = HSEM_TASK_W,
  parameter int ID_W   = HSEM_ID_W
) (
  input  logic [TASK_W-1:0] i_pending,
  input  logic [ID_W-1:0]   i_rr_ptr,
  output logic [ID_W-1:0]   o_grant_idx,
  output logic              o_grant_vld
);

  logic [ID_W-1:0] w_pos;

  // Scan starting at the pointer; the first hit wins.
  always_comb begin
    o_grant_vld = 1'b0;
    o_grant_idx = '0;
    w_pos       = '0;
    for (int i = 0; i < TASK_W; i++) begin
      w_pos = ID_W'((int'(i_rr_ptr) + i) % TASK_W);
      if (!o_grant_vld && i_pending[w_pos]) begin
        o_grant_vld = 1'b1;
        o_grant_idx = w_pos;
      end else begin
        o_grant_vld = o_grant_vld;
      end
    end
  end

endmodule

// File: rtl/hsem_task_dispatch.sv
// Dispatches pending task-request bits to one core, round-robin, one at a time.
// Define HSEM_TASK_TMO_EN to abort a task that runs longer than TMO_CYC cycles.
module hsem_task_dispatch
  import hsem_pkg::*;
#(
  parameter int TASK_W  = HSEM_TASK_W,
  parameter int ID_W    = HSEM_ID_W,
  parameter int TMO_CYC = HSEM_TMO_CYC
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic [TASK_W-1:0] tsk_stat,
  input  logic              tsk_load,
  output logic              task_valid,
  output logic [ID_W-1:0]   task_id,
  input  logic              task_ready,
  input  logic              task_done,
  output logic [TASK_W-1:0] task_clr,
  output logic              busy,
  output logic [ID_W:0]     pend_cnt,
  output logic              tmo_err
);

  if ((TASK_W > (2 ** ID_W)) || (TMO_CYC < 2)) begin : g_param_chk
    $error("hsem_task_dispatch: TASK_W must fit in ID_W bits and TMO_CYC must be >= 2");
  end

  hsem_state_e       r_state;
  logic [TASK_W-1:0] r_pending;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_task_id;
  logic              r_task_valid;
  logic [TASK_W-1:0] r_task_clr;
  logic              r_busy;
  logic [ID_W:0]     r_pend_cnt;
  logic              r_tmo_err;

  logic [TASK_W-1:0] w_onehot;
  logic [TASK_W-1:0] w_clr_vec;
  logic [TASK_W-1:0] w_pending_nxt;
  logic [ID_W:0]     w_popcnt;
  logic [ID_W-1:0]   w_rr_nxt;
  logic [ID_W-1:0]   w_grant_idx;
  logic              w_grant_vld;
  logic              w_tmo_hit;

  hsem_rr_arb #(.TASK_W(TASK_W), .ID_W(ID_W)) u_arb (
    .i_pending   (r_pending),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant_idx (w_grant_idx),
    .o_grant_vld (w_grant_vld)
  );

  assign w_onehot = {{(TASK_W-1){1'b0}}, 1'b1} << r_task_id;
  assign w_rr_nxt = ID_W'(rr_next(int'(r_task_id), TASK_W));

`ifdef HSEM_TASK_TMO_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] r_tmo_cnt;

  // task_done in the expiry cycle takes priority over the timeout.
  assign w_tmo_hit = (r_state == ST_RUN) && !task_done && (r_tmo_cnt == TMO_W'(TMO_CYC - 1));

  // Counts cycles spent in RUN; idle at zero everywhere else.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == ST_RUN) && !task_done && !w_tmo_hit) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end else begin
      r_tmo_cnt <= '0;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  // Retiring slot is cleared on completion or timeout; a same-cycle load re-sets it.
  always_comb begin
    if ((r_state == ST_CMPL) || w_tmo_hit) begin
      w_clr_vec = w_onehot;
    end else begin
      w_clr_vec = '0;
    end
    w_pending_nxt = (r_pending & ~w_clr_vec) | (tsk_load ? tsk_stat : {TASK_W{1'b0}});
  end

  // Population count of the current pending vector.
  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < TASK_W; i++) begin
      w_popcnt = w_popcnt + {{ID_W{1'b0}}, r_pending[i]};
    end
  end

  // Pending vector and its registered count.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_pending  <= '0;
      r_pend_cnt <= '0;
    end else begin
      r_pending  <= w_pending_nxt;
      r_pend_cnt <= w_popcnt;
    end
  end

  // Dispatch FSM with registered handshake and status outputs.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state      <= ST_IDLE;
      r_task_id    <= '0;
      r_task_valid <= 1'b0;
      r_task_clr   <= '0;
      r_busy       <= 1'b0;
      r_rr_ptr     <= '0;
      r_tmo_err    <= 1'b0;
    end else begin
      r_task_clr <= '0;
      r_tmo_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_pending != '0) begin
            r_state <= ST_ARB;
            r_busy  <= 1'b1;
          end
        end
        ST_ARB: begin
          if (w_grant_vld) begin
            r_task_id    <= w_grant_idx;
            r_task_valid <= 1'b1;
            r_state      <= ST_OFFER;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_OFFER: begin
          if (task_ready) begin
            r_task_valid <= 1'b0;
            r_state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (task_done) begin
            r_task_clr <= w_onehot;
            r_state    <= ST_CMPL;
          end else if (w_tmo_hit) begin
            r_tmo_err <= 1'b1;
            r_rr_ptr  <= w_rr_nxt;
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
          end
        end
        ST_CMPL: begin
          r_rr_ptr <= w_rr_nxt;
          r_state  <= ST_IDLE;
          r_busy   <= 1'b0;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_task_valid <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign task_valid = r_task_valid;
  assign task_id    = r_task_id;
  assign task_clr   = r_task_clr;
  assign busy       = r_busy;
  assign pend_cnt   = r_pend_cnt;
  assign tmo_err    = r_tmo_err;

endmodule

// File: tb/tb_hsem_task_dispatch.sv
// Directed self-checking bench for hsem_task_dispatch (TASK_W=32, TMO_CYC=16).
module tb_hsem_task_dispatch;

  logic        hclk;
  logic        hresetn;
  logic [31:0] tsk_stat;
  logic        tsk_load;
  logic        task_valid;
  logic [4:0]  task_id;
  logic        task_ready;
  logic        task_done;
  logic [31:0] task_clr;
  logic        busy;
  logic [5:0]  pend_cnt;
  logic        tmo_err;

  int errors = 0;
  int checks = 0;

  hsem_task_dispatch #(.TASK_W(32), .ID_W(5), .TMO_CYC(16)) dut (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .tsk_stat   (tsk_stat),
    .tsk_load   (tsk_load),
    .task_valid (task_valid),
    .task_id    (task_id),
    .task_ready (task_ready),
    .task_done  (task_done),
    .task_clr   (task_clr),
    .busy       (busy),
    .pend_cnt   (pend_cnt),
    .tmo_err    (tmo_err)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic do_reset();
    hresetn    = 1'b0;
    tsk_stat   = 32'h0;
    tsk_load   = 1'b0;
    task_ready = 1'b0;
    task_done  = 1'b0;
    repeat (2) tick();
    hresetn = 1'b1;
    tick();
  endtask

  task automatic load_pulse(input logic [31:0] v);
    tsk_stat = v;
    tsk_load = 1'b1;
    tick();
    tsk_load = 1'b0;
    tsk_stat = 32'h0;
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (task_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Offer -> accept -> run -> done for one expected task, with optional loads in RUN/CMPL.
  task automatic serve_one(input logic [4:0] exp_id, input logic [31:0] run_load,
                           input logic [31:0] cmpl_load, input string tag);
    bit ok;
    logic [31:0] exp_clr;
    exp_clr = 32'h1 << exp_id;
    wait_valid(20, ok);
    checks++;
    if (!ok || task_id !== exp_id) begin
      errors++;
      $display("FAIL %s_offer: valid=%b id=%0d, expected valid=1 id=%0d", tag, task_valid, task_id, exp_id);
    end
    task_ready = 1'b1;
    tick();
    task_ready = 1'b0;
    if (run_load != 32'h0) load_pulse(run_load);
    else tick();
    checks++;
    if (task_valid !== 1'b0 || task_id !== exp_id) begin
      errors++;
      $display("FAIL %s_run: valid=%b id=%0d, expected valid=0 id=%0d", tag, task_valid, task_id, exp_id);
    end
    task_done = 1'b1;
    tick();
    task_done = 1'b0;
    checks++;
    if (task_clr !== exp_clr) begin
      errors++;
      $display("FAIL %s_clr: got %h expected %h", tag, task_clr, exp_clr);
    end
    if (cmpl_load != 32'h0) load_pulse(cmpl_load);
    else tick();
  endtask

  task automatic test_reset();
    hresetn    = 1'b0;
    tsk_stat   = 32'h0;
    tsk_load   = 1'b0;
    task_ready = 1'b0;
    task_done  = 1'b0;
    repeat (2) tick();
    checks++;
    if ({task_valid, task_id, task_clr, busy, pend_cnt, tmo_err} !== 46'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b id=%0d clr=%h busy=%b cnt=%0d tmo=%b, expected all 0",
               task_valid, task_id, task_clr, busy, pend_cnt, tmo_err);
    end
    hresetn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    load_pulse(32'h1);
    tick();
    checks++;
    if (task_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_early: valid=%b busy=%b, expected valid=0 busy=1", task_valid, busy);
    end
    tick();
    checks++;
    if (task_valid !== 1'b1 || task_id !== 5'd0) begin
      errors++;
      $display("FAIL single_latency: valid=%b id=%0d, expected valid=1 id=0", task_valid, task_id);
    end
    task_ready = 1'b1;
    tick();
    task_ready = 1'b0;
    checks++;
    if (task_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_valid_drop: got %b expected 0", task_valid);
    end
    repeat (3) tick();
    task_done = 1'b1;
    tick();
    task_done = 1'b0;
    checks++;
    if (task_clr !== 32'h1) begin
      errors++;
      $display("FAIL single_clr: got %h expected 00000001", task_clr);
    end
    tick();
    checks++;
    if (task_clr !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: clr=%h busy=%b, expected 0 and 0", task_clr, busy);
    end
    tick();
    checks++;
    if (pend_cnt !== 6'd0) begin
      errors++;
      $display("FAIL single_empty: pend_cnt=%0d expected 0", pend_cnt);
    end
  endtask

  task automatic test_rr_wrap();
    do_reset();
    load_pulse(32'h8000_0001);
    serve_one(5'd0, 32'h0, 32'h0, "rr_a");
    serve_one(5'd31, 32'h8000_0001, 32'h0, "rr_b");
    serve_one(5'd0, 32'h0, 32'h0, "rr_c");
    tick();
    checks++;
    if (pend_cnt !== 6'd0) begin
      errors++;
      $display("FAIL rr_empty: pend_cnt=%0d expected 0", pend_cnt);
    end
    // Pointer at 3 with only bit 1 left: the search must wrap through 31 to 0.
    do_reset();
    load_pulse(32'h5);
    serve_one(5'd0, 32'h0, 32'h0, "wrap_a");
    serve_one(5'd2, 32'h2, 32'h0, "wrap_b");
    serve_one(5'd1, 32'h0, 32'h0, "wrap_c");
  endtask

  task automatic test_load_during_run();
    bit ok;
    do_reset();
    load_pulse(32'h1);
    wait_valid(10, ok);
    checks++;
    if (!ok || task_id !== 5'd0 || pend_cnt !== 6'd1) begin
      errors++;
      $display("FAIL pre_offer: valid=%b id=%0d cnt=%0d, expected 1/0/1", task_valid, task_id, pend_cnt);
    end
    task_ready = 1'b1;
    tick();
    task_ready = 1'b0;
    load_pulse(32'h4);
    tick();
    checks++;
    if (pend_cnt !== 6'd2 || task_id !== 5'd0 || task_valid !== 1'b0) begin
      errors++;
      $display("FAIL pre_no_preempt: cnt=%0d id=%0d valid=%b, expected 2/0/0", pend_cnt, task_id, task_valid);
    end
    task_done = 1'b1;
    tick();
    task_done = 1'b0;
    checks++;
    if (task_clr !== 32'h1) begin
      errors++;
      $display("FAIL pre_clr0: got %h expected 00000001", task_clr);
    end
    repeat (2) tick();
    checks++;
    if (pend_cnt !== 6'd1) begin
      errors++;
      $display("FAIL pre_cnt1: pend_cnt=%0d expected 1", pend_cnt);
    end
    serve_one(5'd2, 32'h0, 32'h0, "pre_b");
    tick();
    checks++;
    if (pend_cnt !== 6'd0) begin
      errors++;
      $display("FAIL pre_cnt0: pend_cnt=%0d expected 0", pend_cnt);
    end
  endtask

  task automatic test_reload_cmpl();
    do_reset();
    load_pulse(32'h8);
    serve_one(5'd3, 32'h0, 32'h8, "rl_a");
    tick();
    checks++;
    if (pend_cnt !== 6'd1) begin
      errors++;
      $display("FAIL rl_kept: pend_cnt=%0d expected 1", pend_cnt);
    end
    serve_one(5'd3, 32'h0, 32'h0, "rl_b");
    tick();
    checks++;
    if (pend_cnt !== 6'd0) begin
      errors++;
      $display("FAIL rl_empty: pend_cnt=%0d expected 0", pend_cnt);
    end
  endtask

  task automatic test_stall();
    bit ok;
    int bad;
    do_reset();
    load_pulse(32'h20);
    wait_valid(10, ok);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      task_done = (i == 10);
      tsk_load  = (i == 20);
      tsk_stat  = 32'h0;
      tick();
      if (task_valid !== 1'b1 || task_id !== 5'd5 || task_clr !== 32'h0) bad++;
    end
    task_done = 1'b0;
    tsk_load  = 1'b0;
    checks++;
    if (!ok || bad != 0) begin
      errors++;
      $display("FAIL stall_hold: %0d bad cycles, expected 0 (valid=1 id=5 clr=0)", bad);
    end
    checks++;
    if (pend_cnt !== 6'd1) begin
      errors++;
      $display("FAIL stall_zero_load: pend_cnt=%0d expected 1", pend_cnt);
    end
    serve_one(5'd5, 32'h0, 32'h0, "stall");
  endtask

  task automatic test_load_zero();
    do_reset();
    load_pulse(32'h0);
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || pend_cnt !== 6'd0 || task_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_load: busy=%b cnt=%0d valid=%b, expected 0/0/0", busy, pend_cnt, task_valid);
    end
  endtask

`ifdef HSEM_TASK_TMO_EN
  task automatic test_timeout();
    bit ok;
    int bad;
    do_reset();
    load_pulse(32'h2);
    wait_valid(10, ok);
    task_ready = 1'b1;
    tick();
    task_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (tmo_err !== 1'b0 || task_clr !== 32'h0 || busy !== 1'b1) bad++;
    end
    checks++;
    if (!ok || bad != 0) begin
      errors++;
      $display("FAIL tmo_early: %0d bad cycles before expiry, expected 0", bad);
    end
    tick();
    checks++;
    if (tmo_err !== 1'b1 || task_clr !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_pulse: tmo=%b clr=%h busy=%b, expected 1/0/0", tmo_err, task_clr, busy);
    end
    tick();
    checks++;
    if (tmo_err !== 1'b0 || pend_cnt !== 6'd0) begin
      errors++;
      $display("FAIL tmo_after: tmo=%b cnt=%0d, expected 0/0", tmo_err, pend_cnt);
    end
    load_pulse(32'h2);
    wait_valid(10, ok);
    task_ready = 1'b1;
    tick();
    task_ready = 1'b0;
    repeat (15) tick();
    task_done = 1'b1;
    tick();
    task_done = 1'b0;
    checks++;
    if (tmo_err !== 1'b0 || task_clr !== 32'h2) begin
      errors++;
      $display("FAIL tmo_done_wins: tmo=%b clr=%h, expected 0/00000002", tmo_err, task_clr);
    end
  endtask
`else
  task automatic test_timeout();
    bit ok;
    int bad;
    do_reset();
    load_pulse(32'h2);
    wait_valid(10, ok);
    task_ready = 1'b1;
    tick();
    task_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (tmo_err !== 1'b0 || busy !== 1'b1 || task_valid !== 1'b0 || task_clr !== 32'h0) bad++;
    end
    checks++;
    if (!ok || bad != 0) begin
      errors++;
      $display("FAIL no_tmo_wait: %0d bad cycles, expected 0", bad);
    end
    task_done = 1'b1;
    tick();
    task_done = 1'b0;
    checks++;
    if (task_clr !== 32'h2) begin
      errors++;
      $display("FAIL no_tmo_clr: got %h expected 00000002", task_clr);
    end
  endtask
`endif

  task automatic test_reset_mid();
    bit ok;
    int bad;
    do_reset();
    load_pulse(32'h10);
    wait_valid(10, ok);
    task_ready = 1'b1;
    tick();
    task_ready = 1'b0;
    repeat (3) tick();
    hresetn = 1'b0;
    #1;
    checks++;
    if (!ok || {task_valid, task_id, task_clr, busy, pend_cnt, tmo_err} !== 46'd0) begin
      errors++;
      $display("FAIL midreset_outputs: valid=%b id=%0d clr=%h busy=%b cnt=%0d tmo=%b, expected all 0",
               task_valid, task_id, task_clr, busy, pend_cnt, tmo_err);
    end
    tick();
    hresetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (task_clr !== 32'h0 || busy !== 1'b0 || pend_cnt !== 6'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midreset_abandon: %0d bad cycles after release, expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_wrap();
    test_load_during_run();
    test_reload_cmpl();
    test_stall();
    test_load_zero();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
